// File: rtl/tpu_seq_if.sv
// Host/buffer-facing bundle for the systolic tile sequencer.
// master = sequencer side, slave = host and tile-buffer side.
interface tpu_seq_if #(
  parameter int DIM    = 8,
  parameter int STEP_W = $clog2(3*DIM-2),
  parameter int ROW_W  = $clog2(DIM)
);
  logic              start;
  logic              stall;
  logic              busy;
  logic              done;
  logic              arr_en;
  logic              arr_wren;
  logic [ROW_W-1:0]  c_wr_row;
  logic [STEP_W-1:0] step;
  logic [DIM-1:0]    lane_mask;
  logic [ROW_W-1:0]  c_rd_row;
  logic              c_rd_valid;
  logic              c_rd_ready;

  modport master (
    input  start, stall, c_rd_ready,
    output busy, done, arr_en, arr_wren, c_wr_row, step, lane_mask,
           c_rd_row, c_rd_valid
  );

  modport slave (
    output start, stall, c_rd_ready,
    input  busy, done, arr_en, arr_wren, c_wr_row, step, lane_mask,
           c_rd_row, c_rd_valid
  );
endinterface

// File: rtl/tpu_seq.sv
// One-tile sequencer for a DIM x DIM systolic MAC array: preload C, stream
// skewed A/B, drain C rows, pulse done.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start
// LOAD    | writing preload C rows 0..DIM-1 into the array (WrEn)
// COMPUTE | streaming skewed A/B, steps 0..3*DIM-3
// READ    | presenting C rows 0..DIM-1 to the consumer (valid/ready)
// DONE    | single-cycle completion pulse
module tpu_seq #(
  parameter int DIM    = 8,
  parameter int STEP_W = $clog2(3*DIM-2),
  parameter int ROW_W  = $clog2(DIM)
) (
  input logic        clk,
  input logic        rst,
  tpu_seq_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    COMPUTE = 3'd2,
    READ    = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [STEP_W-1:0] ROW_LAST  = STEP_W'(DIM - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(3*DIM - 3);

  state_t            state;
  logic [STEP_W-1:0] cnt;
  logic [STEP_W-1:0] cnt_inc;

  logic              busy_q;
  logic              done_q;
  logic              en_q;
  logic              wren_q;
  logic [ROW_W-1:0]  wr_row_q;
  logic [STEP_W-1:0] step_q;
  logic [DIM-1:0]    mask_q;
  logic [ROW_W-1:0]  rd_row_q;
  logic              rd_valid_q;

  assign cnt_inc = cnt + 1'b1;

  // Lane i carries A[i][s-i] / B[s-i][i] only while 0 <= s-i < DIM.
  function automatic logic [DIM-1:0] mask_of(input logic [STEP_W-1:0] s);
    logic [DIM-1:0] m;
    m = '0;
    for (int i = 0; i < DIM; i++) begin
      m[i] = (i <= int'(s)) && (int'(s) < i + DIM);
    end
    return m;
  endfunction

  // arr_en is registered, so a stall seen at an edge blanks the following
  // cycle; the counters only advance on edges that close an enabled cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      en_q       <= 1'b0;
      wren_q     <= 1'b0;
      wr_row_q   <= '0;
      step_q     <= '0;
      mask_q     <= '0;
      rd_row_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= LOAD;
            cnt      <= '0;
            busy_q   <= 1'b1;
            en_q     <= !bus.stall;
            wren_q   <= !bus.stall;
            wr_row_q <= '0;
          end
        end

        LOAD: begin
          en_q   <= !bus.stall;
          wren_q <= !bus.stall;
          if (en_q) begin
            if (cnt == ROW_LAST) begin
              state    <= COMPUTE;
              cnt      <= '0;
              wren_q   <= 1'b0;
              wr_row_q <= '0;
              step_q   <= '0;
              mask_q   <= mask_of('0);
            end else begin
              cnt      <= cnt_inc;
              wr_row_q <= cnt_inc[ROW_W-1:0];
            end
          end
        end

        COMPUTE: begin
          en_q <= !bus.stall;
          if (en_q) begin
            if (cnt == STEP_LAST) begin
              state      <= READ;
              cnt        <= '0;
              en_q       <= 1'b0;
              step_q     <= '0;
              mask_q     <= '0;
              rd_row_q   <= '0;
              rd_valid_q <= 1'b1;
            end else begin
              cnt    <= cnt_inc;
              step_q <= cnt_inc;
              mask_q <= mask_of(cnt_inc);
            end
          end
        end

        READ: begin
          if (rd_valid_q && bus.c_rd_ready) begin
            if (cnt == ROW_LAST) begin
              state      <= DONE;
              cnt        <= '0;
              rd_row_q   <= '0;
              rd_valid_q <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              cnt      <= cnt_inc;
              rd_row_q <= cnt_inc[ROW_W-1:0];
            end
          end
        end

        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.arr_en     = en_q;
  assign bus.arr_wren   = wren_q;
  assign bus.c_wr_row   = wr_row_q;
  assign bus.step       = step_q;
  assign bus.lane_mask  = mask_q;
  assign bus.c_rd_row   = rd_row_q;
  assign bus.c_rd_valid = rd_valid_q;

endmodule

// File: tb/tb_tpu_seq.sv
// Directed bench for tpu_seq (DIM=8) with a behavioural 8x8 MAC array model.
module tb_tpu_seq;
  localparam int DIM = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tpu_seq_if #(.DIM(DIM)) bus();
  tpu_seq #(.DIM(DIM)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  wire [23:0] outs = {bus.busy, bus.done, bus.arr_en, bus.arr_wren, bus.c_wr_row,
                      bus.step, bus.lane_mask, bus.c_rd_row, bus.c_rd_valid};

  // per-cycle trace of one tile, cycle 0 = first LOAD cycle
  logic       en_tr[128], wren_tr[128], valid_tr[128], rdy_tr[128], done_tr[128], busy_tr[128];
  logic [4:0] step_tr[128];
  logic [2:0] wrow_tr[128], rrow_tr[128];
  logic [7:0] mask_tr[128];
  int n_cyc, done_cycle;
  int wren_n, wrow_bad, en_n, rd_n, rrow_bad, done_n, last_xfer;

  // array model
  int   a_m[DIM][DIM], b_m[DIM][DIM];
  int   a_r[DIM][DIM], b_r[DIM][DIM], c_m[DIM][DIM];
  logic model_clr = 1'b1;

  function automatic int a_in(int i, int j);
    if (j != 0) return a_r[i][j-1];
    if (bus.lane_mask[i]) return a_m[i][int'(bus.step) - i];
    return 0;
  endfunction

  function automatic int b_in(int i, int j);
    if (i != 0) return b_r[i-1][j];
    if (bus.lane_mask[j]) return b_m[int'(bus.step) - j][j];
    return 0;
  endfunction

  always @(negedge clk) begin
    if (model_clr) begin
      for (int i = 0; i < DIM; i++)
        for (int j = 0; j < DIM; j++) begin
          c_m[i][j] <= 0;
          a_r[i][j] <= 0;
          b_r[i][j] <= 0;
        end
    end else if (bus.arr_en && bus.arr_wren) begin
      for (int j = 0; j < DIM; j++) c_m[bus.c_wr_row][j] <= 1;
    end else if (bus.arr_en) begin
      for (int i = 0; i < DIM; i++)
        for (int j = 0; j < DIM; j++) begin
          c_m[i][j] <= c_m[i][j] + a_in(i, j) * b_in(i, j);
          a_r[i][j] <= a_in(i, j);
          b_r[i][j] <= b_in(i, j);
        end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0 nominal, 1 stalls (LOAD row 2, 3 cycles at s=5), 2 ready toggling + stall in READ, 3 start held
  task automatic run_tile(input int mode);
    done_cycle = -1;
    n_cyc = 0;
    bus.start = 1'b1;
    tick();
    if (mode != 3) bus.start = 1'b0;
    for (int c = 0; c < 128; c++) begin
      bus.c_rd_ready = (mode == 2) ? (c % 2 == 1) : 1'b1;
      en_tr[c] = bus.arr_en;       wren_tr[c] = bus.arr_wren;
      valid_tr[c] = bus.c_rd_valid; rdy_tr[c] = bus.c_rd_ready;
      done_tr[c] = bus.done;       busy_tr[c] = bus.busy;
      step_tr[c] = bus.step;       mask_tr[c] = bus.lane_mask;
      wrow_tr[c] = bus.c_wr_row;   rrow_tr[c] = bus.c_rd_row;
      n_cyc = c + 1;
      if (bus.done && done_cycle < 0) done_cycle = c;
      if (done_cycle >= 0 && c >= done_cycle + 2) break;
      bus.stall = (mode == 1 && (c == 1 || c == 13 || c == 14 || c == 15)) ||
                  (mode == 2 && bus.c_rd_valid);
      tick();
    end
    bus.start = 1'b0;
    bus.stall = 1'b0;
    bus.c_rd_ready = 1'b1;
  endtask

  task automatic tally(input int limit);
    wren_n = 0; wrow_bad = 0; en_n = 0; rd_n = 0; rrow_bad = 0; done_n = 0; last_xfer = -1;
    for (int c = 0; c < limit && c < n_cyc; c++) begin
      if (wren_tr[c]) begin
        if (int'(wrow_tr[c]) != wren_n) wrow_bad++;
        wren_n++;
      end
      if (en_tr[c]) en_n++;
      if (valid_tr[c] && rdy_tr[c]) begin
        if (int'(rrow_tr[c]) != rd_n) rrow_bad++;
        rd_n++;
        last_xfer = c;
      end
      if (done_tr[c]) done_n++;
    end
  endtask

  task automatic test_reset();
    int found;
    #12;
    checks++; if (outs !== 24'h0) begin errors++; $display("FAIL reset_outputs: got %h expected 000000", outs); end
    @(negedge clk) rst = 1'b0;
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy=%b expected 0", bus.busy); end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    found = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.step == 5'd10 && bus.arr_en && !bus.arr_wren) begin found = 1; break; end
      tick();
    end
    checks++; if (found !== 1) begin errors++; $display("FAIL reach_s10: found=%0d expected 1", found); end
    #2 rst = 1'b1;
    #1;
    checks++; if (outs !== 24'h0) begin errors++; $display("FAIL reset_mid_compute: got %h expected 000000", outs); end
    tick();
    checks++; if (outs !== 24'h0) begin errors++; $display("FAIL reset_held: got %h expected 000000", outs); end
    @(negedge clk) rst = 1'b0;
    run_tile(0);
    tally(n_cyc);
    checks++; if (done_cycle !== 38) begin errors++; $display("FAIL clean_tile_done: got %0d expected 38", done_cycle); end
    checks++; if (wren_n !== 8 || wrow_bad !== 0) begin errors++; $display("FAIL clean_tile_load: wren=%0d bad=%0d expected 8/0", wren_n, wrow_bad); end
  endtask

  task automatic test_nominal();
    run_tile(0);
    tally(n_cyc);
    checks++; if (wren_n !== 8) begin errors++; $display("FAIL nom_wren_count: got %0d expected 8", wren_n); end
    checks++; if (wrow_bad !== 0) begin errors++; $display("FAIL nom_wr_rows: %0d out of order, expected 0", wrow_bad); end
    checks++; if (en_n !== 30) begin errors++; $display("FAIL nom_en_count: got %0d expected 30", en_n); end
    checks++; if (mask_tr[8] !== 8'h01 || step_tr[8] !== 5'd0) begin errors++; $display("FAIL nom_mask_s0: mask=%h step=%0d expected 01/0", mask_tr[8], step_tr[8]); end
    checks++; if (mask_tr[11] !== 8'h0F) begin errors++; $display("FAIL nom_mask_s3: got %h expected 0f", mask_tr[11]); end
    checks++; if (mask_tr[15] !== 8'hFF) begin errors++; $display("FAIL nom_mask_s7: got %h expected ff", mask_tr[15]); end
    checks++; if (mask_tr[18] !== 8'hF8) begin errors++; $display("FAIL nom_mask_s10: got %h expected f8", mask_tr[18]); end
    checks++; if (mask_tr[22] !== 8'h80) begin errors++; $display("FAIL nom_mask_s14: got %h expected 80", mask_tr[22]); end
    checks++; if (step_tr[29] !== 5'd21 || mask_tr[29] !== 8'h00) begin errors++; $display("FAIL nom_last_step: step=%0d mask=%h expected 21/00", step_tr[29], mask_tr[29]); end
    checks++; if (mask_tr[30] !== 8'h00 || step_tr[30] !== 5'd0) begin errors++; $display("FAIL nom_read_idle_mask: mask=%h step=%0d expected 00/0", mask_tr[30], step_tr[30]); end
    checks++; if (rd_n !== 8 || rrow_bad !== 0) begin errors++; $display("FAIL nom_reads: beats=%0d bad=%0d expected 8/0", rd_n, rrow_bad); end
    checks++; if (done_cycle !== 38) begin errors++; $display("FAIL nom_done_cycle: got %0d expected 38", done_cycle); end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL nom_done_width: got %0d expected 1", done_n); end
    checks++; if (busy_tr[39] !== 1'b0) begin errors++; $display("FAIL nom_idle_after_done: busy=%b expected 0", busy_tr[39]); end
  endtask

  task automatic test_stall();
    int held;
    run_tile(1);
    tally(n_cyc);
    checks++; if (en_tr[2] !== 1'b0 || wrow_tr[2] !== 3'd2) begin errors++; $display("FAIL stall_load_gap: en=%b row=%0d expected 0/2", en_tr[2], wrow_tr[2]); end
    checks++; if (en_tr[3] !== 1'b1 || wrow_tr[3] !== 3'd2) begin errors++; $display("FAIL stall_load_resume: en=%b row=%0d expected 1/2", en_tr[3], wrow_tr[3]); end
    checks++; if (step_tr[13] !== 5'd4 || en_tr[13] !== 1'b1) begin errors++; $display("FAIL stall_pre_s4: step=%0d en=%b expected 4/1", step_tr[13], en_tr[13]); end
    held = 0;
    for (int c = 14; c <= 16; c++) if (en_tr[c] === 1'b0 && step_tr[c] === 5'd5) held++;
    checks++; if (held !== 3) begin errors++; $display("FAIL stall_s5_held: got %0d cycles expected 3", held); end
    checks++; if (step_tr[17] !== 5'd5 || en_tr[17] !== 1'b1) begin errors++; $display("FAIL stall_s5_resume: step=%0d en=%b expected 5/1", step_tr[17], en_tr[17]); end
    checks++; if (step_tr[18] !== 5'd6) begin errors++; $display("FAIL stall_s6: got %0d expected 6", step_tr[18]); end
    checks++; if (en_n !== 30 || wren_n !== 8 || wrow_bad !== 0) begin errors++; $display("FAIL stall_beats: en=%0d wren=%0d bad=%0d expected 30/8/0", en_n, wren_n, wrow_bad); end
    checks++; if (done_cycle !== 42) begin errors++; $display("FAIL stall_done_cycle: got %0d expected 42", done_cycle); end
  endtask

  task automatic test_backpressure();
    int hold_bad;
    run_tile(2);
    tally(n_cyc);
    hold_bad = 0;
    for (int c = 1; c < n_cyc; c++)
      if (valid_tr[c] && valid_tr[c-1] && !rdy_tr[c-1] && rrow_tr[c] != rrow_tr[c-1]) hold_bad++;
    checks++; if (rd_n !== 8 || rrow_bad !== 0) begin errors++; $display("FAIL bp_reads: beats=%0d bad=%0d expected 8/0", rd_n, rrow_bad); end
    checks++; if (hold_bad !== 0) begin errors++; $display("FAIL bp_row_hold: %0d moves without transfer, expected 0", hold_bad); end
    checks++; if (rrow_tr[32] !== 3'd1 || rrow_tr[33] !== 3'd1) begin errors++; $display("FAIL bp_row_at_32: got %0d/%0d expected 1/1", rrow_tr[32], rrow_tr[33]); end
    checks++; if (done_cycle !== 46) begin errors++; $display("FAIL bp_done_cycle: got %0d expected 46", done_cycle); end
    checks++; if (done_cycle !== last_xfer + 1) begin errors++; $display("FAIL bp_done_after_row7: done=%0d last_xfer=%0d expected done=last+1", done_cycle, last_xfer); end
    checks++; if (en_n !== 30) begin errors++; $display("FAIL bp_en_count: got %0d expected 30", en_n); end
  endtask

  task automatic test_start_held();
    int busy_n, seen;
    run_tile(3);
    tally(done_cycle + 1);
    busy_n = 0;
    for (int c = 0; c <= 38 && c < n_cyc; c++) if (busy_tr[c]) busy_n++;
    checks++; if (done_cycle !== 38) begin errors++; $display("FAIL held_done_cycle: got %0d expected 38", done_cycle); end
    checks++; if (wren_n !== 8 || wrow_bad !== 0) begin errors++; $display("FAIL held_no_retrigger: wren=%0d bad=%0d expected 8/0", wren_n, wrow_bad); end
    checks++; if (busy_n !== 39) begin errors++; $display("FAIL held_busy: got %0d expected 39", busy_n); end
    checks++; if (busy_tr[39] !== 1'b0) begin errors++; $display("FAIL held_idle_gap: busy=%b expected 0", busy_tr[39]); end
    checks++; if (wren_tr[40] !== 1'b1 || wrow_tr[40] !== 3'd0) begin errors++; $display("FAIL held_next_load: wren=%b row=%0d expected 1/0", wren_tr[40], wrow_tr[40]); end
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      if (bus.done) begin seen = 1; break; end
      tick();
    end
    checks++; if (seen !== 1) begin errors++; $display("FAIL held_second_done: seen=%0d expected 1", seen); end
    tick();
  endtask

  task automatic test_e2e();
    int bad, first_got, first_exp;
    model_clr = 1'b1;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        a_m[i][j] = (i == j) ? 1 : 0;
        b_m[i][j] = int'($urandom_range(0, 255)) - 128;
      end
    tick();
    tick();
    model_clr = 1'b0;
    run_tile(1);
    tally(n_cyc);
    checks++; if (rd_n !== 8) begin errors++; $display("FAIL e2e_beats: got %0d expected 8", rd_n); end
    for (int r = 0; r < DIM; r++) begin
      bad = 0; first_got = 0; first_exp = 0;
      for (int j = 0; j < DIM; j++)
        if (c_m[r][j] != b_m[r][j] + 1) begin
          if (bad == 0) begin first_got = c_m[r][j]; first_exp = b_m[r][j] + 1; end
          bad++;
        end
      checks++; if (bad !== 0) begin errors++; $display("FAIL e2e_row%0d: %0d cols wrong, first got %0d expected %0d", r, bad, first_got, first_exp); end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stall = 1'b0;
    bus.c_rd_ready = 1'b1;
    test_reset();
    test_nominal();
    test_stall();
    test_backpressure();
    test_start_held();
    test_e2e();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t exceeded limit 100000", $time);
    $fatal(1);
  end

endmodule
